exhaustive_sweep_checker: RTL and testbench

Synthesizable, parametrised exhaustive stimulus sweeper and self-checker for combinational blocks (gates, ALU slices) of up to IN_W inputs. On `start` it drives every input vector once, in binary or Gray order, and holds each vector for HOLD cycles. At the end of each hold window it compares the DUT output against a golden-model output. It reports mismatch count, the first failing vector and a pass/done status. It sits in the verification and bring-up harness beside the ALU and its sub-gates.

---
 rtl/sweep_pkg.sv | 20 ++
 rtl/sweep_hold_timer.sv | 31 +++
 rtl/exhaustive_sweep_checker.sv | 114 +++++++++++
 tb/tb_exhaustive_sweep_checker.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// Shared types and helpers for the exhaustive sweep checker.
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } sweep_state_t;

    localparam logic MODE_BIN  = 1'b0;
    localparam logic MODE_GRAY = 1'b1;

    // Reflected Gray code of value, truncated to the low 'width' bits.
    function automatic logic [31:0] gray_enc(input logic [31:0] value, input int width);
        logic [31:0] mask;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value ^ (value >> 1)) & mask;
    endfunction

endpackage

// File: rtl/sweep_hold_timer.sv
// Counts 0..HOLD-1 while enabled; 'last' marks the final cycle of a hold window.
module sweep_hold_timer #(
    parameter int HOLD = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic last
);

    localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] LAST_VAL = CW'(HOLD - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            if (count == LAST_VAL) begin
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

    assign last = (count == LAST_VAL);

endmodule

// File: rtl/exhaustive_sweep_checker.sv
// Drives every IN_W-bit vector (binary or Gray order) to a DUT and a golden model,
// comparing outputs at the end of each HOLD-cycle window.
module exhaustive_sweep_checker #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 4,
    parameter int HOLD  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    output logic [IN_W-1:0]  stim,
    input  logic [OUT_W-1:0] dut_out,
    input  logic [OUT_W-1:0] ref_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [IN_W:0]    err_count,
    output logic             first_fail_valid,
    output logic [IN_W-1:0]  first_fail_vec,
    output logic [OUT_W-1:0] first_fail_got
);

    import sweep_pkg::*;

    localparam logic [IN_W-1:0] IDX_LAST = '1;
    localparam logic [IN_W:0]   ERR_ONE  = 1;

    sweep_state_t    state, state_next;
    logic [IN_W-1:0] idx;
    logic            mode_q;
    logic            hold_last;
    logic            start_ok;
    logic            compare;
    logic            mismatch;
    logic [31:0]     gray_full;

    assign start_ok = start && (state != DRIVE);
    assign compare  = (state == DRIVE) && hold_last;
    assign mismatch = compare && (dut_out != ref_out);

    sweep_hold_timer #(.HOLD(HOLD)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr  (start_ok),
        .en   (state == DRIVE),
        .last (hold_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        pass       = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) state_next = DRIVE;
            end
            DRIVE: begin
                busy = 1'b1;
                if (compare && (idx == IDX_LAST)) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                pass = (err_count == '0);
                if (start_ok) state_next = DRIVE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Index stays at the terminal vector in DONE so stim keeps showing the last vector.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx              <= '0;
            mode_q           <= MODE_BIN;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            first_fail_got   <= '0;
        end else if (start_ok) begin
            idx              <= '0;
            mode_q           <= mode;
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
            first_fail_got   <= '0;
        end else if (compare) begin
            if (mismatch) begin
                err_count <= err_count + ERR_ONE;
                if (!first_fail_valid) begin
                    first_fail_valid <= 1'b1;
                    first_fail_vec   <= stim;
                    first_fail_got   <= dut_out;
                end
            end
            if (idx != IDX_LAST) begin
                idx <= idx + 1'b1;
            end
        end
    end

    assign gray_full = gray_enc(32'(idx), IN_W);
    assign stim      = (mode_q == MODE_GRAY) ? gray_full[IN_W-1:0] : idx;

endmodule

// File: tb/tb_exhaustive_sweep_checker.sv
// Self-checking bench: table-driven sweeps plus scoreboard of expected stim per busy cycle.
module tb_exhaustive_sweep_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start1;
    logic        mode;
    logic [15:0] fault_mask;

    logic [3:0] stim4, dut4_out, ref4_out, ffvec4, ffgot4;
    logic [4:0] err4;
    logic       busy4, done4, pass4, ffv4;

    logic [3:0] stim1, dut1_out, ref1_out, ffvec1, ffgot1;
    logic [4:0] err1;
    logic       busy1, done1, pass1, ffv1;

    int checks = 0;
    int errors = 0;

    logic [3:0] q4[$];
    logic [3:0] q1[$];

    always #5 clk = ~clk;

    // Golden model is stim+9; a faulted vector returns the golden value xor 6.
    assign ref4_out = stim4 + 4'd9;
    assign dut4_out = fault_mask[stim4] ? (ref4_out ^ 4'h6) : ref4_out;
    assign ref1_out = stim1 + 4'd9;
    assign dut1_out = ref1_out;

    exhaustive_sweep_checker #(.IN_W(4), .OUT_W(4), .HOLD(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .stim(stim4),
        .dut_out(dut4_out), .ref_out(ref4_out), .busy(busy4), .done(done4),
        .pass(pass4), .err_count(err4), .first_fail_valid(ffv4),
        .first_fail_vec(ffvec4), .first_fail_got(ffgot4)
    );

    exhaustive_sweep_checker #(.IN_W(4), .OUT_W(4), .HOLD(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .mode(mode), .stim(stim1),
        .dut_out(dut1_out), .ref_out(ref1_out), .busy(busy1), .done(done1),
        .pass(pass1), .err_count(err1), .first_fail_valid(ffv1),
        .first_fail_vec(ffvec1), .first_fail_got(ffgot1)
    );

    typedef struct {
        logic        m;
        logic [15:0] mask;
        int          err;
        logic        pass;
        logic        ffv;
        logic [3:0]  vec;
        logic [3:0]  got;
    } sweep_vec_t;

    sweep_vec_t table_v[6];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] expEnc(input logic m, input int k);
        logic [3:0] v;
        v = 4'(k);
        return m ? (v ^ (v >> 1)) : v;
    endfunction

    always @(negedge clk) begin
        if (busy4) begin
            if (q4.size() == 0) checkOutput("stim4 unexpected busy", {28'd0, stim4}, 32'hFFFF);
            else checkOutput("stim4 sequence", {28'd0, stim4}, {28'd0, q4.pop_front()});
        end
        if (busy1) begin
            if (q1.size() == 0) checkOutput("stim1 unexpected busy", {28'd0, stim1}, 32'hFFFF);
            else checkOutput("stim1 sequence", {28'd0, stim1}, {28'd0, q1.pop_front()});
        end
    end

    task automatic applyStimulus(input logic m, input logic [15:0] mask);
        mode       = m;
        fault_mask = mask;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 0; k < 16; k++)
            for (int h = 0; h < 4; h++)
                q4.push_back(expEnc(m, k));
    endtask

    task automatic waitDone(input int already, output int cycles);
        cycles = already;
        while (!done4 && cycles < 300) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic checkIdleZero(input string tag);
        checkOutput({tag, " stim"}, stim4, 0);
        checkOutput({tag, " busy"}, busy4, 0);
        checkOutput({tag, " done"}, done4, 0);
        checkOutput({tag, " pass"}, pass4, 0);
        checkOutput({tag, " err_count"}, err4, 0);
        checkOutput({tag, " ff_valid"}, ffv4, 0);
        checkOutput({tag, " ff_vec"}, ffvec4, 0);
        checkOutput({tag, " ff_got"}, ffgot4, 0);
    endtask

    initial begin
        int cyc;

        table_v[0] = '{1'b0, 16'h0000,  0, 1'b1, 1'b0, 4'h0, 4'h0};
        table_v[1] = '{1'b0, 16'h0400,  1, 1'b0, 1'b1, 4'hA, 4'h5};
        table_v[2] = '{1'b0, 16'h0208,  2, 1'b0, 1'b1, 4'h3, 4'hA};
        table_v[3] = '{1'b1, 16'h0208,  2, 1'b0, 1'b1, 4'h3, 4'hA};
        table_v[4] = '{1'b1, 16'h1100,  2, 1'b0, 1'b1, 4'hC, 4'h3};
        table_v[5] = '{1'b0, 16'hFFFF, 16, 1'b0, 1'b1, 4'h0, 4'hF};

        rst = 1'b1; start = 1'b0; start1 = 1'b0; mode = 1'b0; fault_mask = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkIdleZero("reset");

        for (int i = 0; i < 6; i++) begin
            applyStimulus(table_v[i].m, table_v[i].mask);
            waitDone(0, cyc);
            checkOutput($sformatf("vec%0d done cycles", i), cyc, 64);
            checkOutput($sformatf("vec%0d busy", i), busy4, 0);
            checkOutput($sformatf("vec%0d err_count", i), err4, table_v[i].err);
            checkOutput($sformatf("vec%0d pass", i), pass4, table_v[i].pass);
            checkOutput($sformatf("vec%0d ff_valid", i), ffv4, table_v[i].ffv);
            checkOutput($sformatf("vec%0d ff_vec", i), ffvec4, table_v[i].vec);
            checkOutput($sformatf("vec%0d ff_got", i), ffgot4, table_v[i].got);
            checkOutput($sformatf("vec%0d queue drained", i), q4.size(), 0);
        end

        // Restart from DONE after a failing sweep must clear the results.
        applyStimulus(1'b0, 16'h0000);
        checkOutput("restart err_count", err4, 0);
        checkOutput("restart ff_valid", ffv4, 0);
        checkOutput("restart done", done4, 0);
        checkOutput("restart busy", busy4, 1);
        waitDone(0, cyc);
        checkOutput("restart cycles", cyc, 64);
        checkOutput("restart pass", pass4, 1);

        applyStimulus(1'b0, 16'h0000);
        repeat (10) begin @(posedge clk); #1; end
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        waitDone(11, cyc);
        checkOutput("start in drive cycles", cyc, 64);
        checkOutput("start in drive pass", pass4, 1);

        applyStimulus(1'b0, 16'h0002);
        repeat (19) begin @(posedge clk); #1; end
        checkOutput("pre-reset ff_valid", ffv4, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q4.delete();
        checkIdleZero("mid reset");

        rst = 1'b1; start = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        checkOutput("rst beats start busy", busy4, 0);

        applyStimulus(1'b0, 16'h0000);
        waitDone(0, cyc);
        checkOutput("post-reset cycles", cyc, 64);
        checkOutput("post-reset pass", pass4, 1);
        checkOutput("post-reset err_count", err4, 0);

        mode = 1'b1; fault_mask = '0; start1 = 1'b1;
        @(posedge clk);
        #1;
        start1 = 1'b0;
        for (int k = 0; k < 16; k++) q1.push_back(expEnc(1'b1, k));
        cyc = 0;
        while (!done1 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("hold1 cycles", cyc, 16);
        checkOutput("hold1 pass", pass1, 1);
        checkOutput("hold1 busy", busy1, 0);
        checkOutput("hold1 last stim", stim1, 4'h8);
        checkOutput("hold1 queue drained", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
